// File: rtl/rand_delay_timer.sv
// rtl/rand_delay_timer.sv - random hold-off timer fed by the LFSR; pulses time_out when the delay expires
module rand_delay_timer #(
  parameter int WIDTH     = 7,
  parameter int RETRIGGER = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             trigger,
  input  logic [WIDTH-1:0] rnd_in,
  output logic             lfsr_en,
  output logic             busy,
  output logic             time_out,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] load_val;

  // A zero from the LFSR would otherwise wrap the counter on its first decrement
  assign load_val = (rnd_in == '0) ? WIDTH'(1) : rnd_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      lfsr_en  <= 1'b0;
      time_out <= 1'b0;
    end else begin
      lfsr_en  <= 1'b0;
      time_out <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            count   <= load_val;
            state   <= COUNT;
            busy    <= 1'b1;
            lfsr_en <= 1'b1;
          end
        end
        COUNT: begin
          if ((RETRIGGER != 0) && trigger) begin
            count   <= load_val;
            lfsr_en <= 1'b1;
          end else if (en) begin
            if (count == WIDTH'(1)) begin
              count    <= '0;
              state    <= DONE;
              busy     <= 1'b0;
              time_out <= 1'b1;
            end else begin
              count <= count - WIDTH'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          count <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_delay_timer.sv
// tb/tb_rand_delay_timer.sv - directed-vector bench; d0 built with RETRIGGER=0, d1 with RETRIGGER=1
module tb_rand_delay_timer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       trigger;
  logic [6:0] rnd_in;
  logic       lfsr_en0, busy0, time_out0;
  logic [6:0] count0;
  logic       lfsr_en1, busy1, time_out1;
  logic [6:0] count1;

  int total = 0;
  int bad   = 0;

  rand_delay_timer #(.WIDTH(7), .RETRIGGER(0)) d0 (
    .clk(clk), .rst(rst), .en(en), .trigger(trigger), .rnd_in(rnd_in),
    .lfsr_en(lfsr_en0), .busy(busy0), .time_out(time_out0), .count(count0)
  );

  rand_delay_timer #(.WIDTH(7), .RETRIGGER(1)) d1 (
    .clk(clk), .rst(rst), .en(en), .trigger(trigger), .rnd_in(rnd_in),
    .lfsr_en(lfsr_en1), .busy(busy1), .time_out(time_out1), .count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_both(input string tag, input int c, input int b, input int l, input int t);
    chk({tag, " d0.count"},    int'(count0),    c);
    chk({tag, " d0.busy"},     int'(busy0),     b);
    chk({tag, " d0.lfsr_en"},  int'(lfsr_en0),  l);
    chk({tag, " d0.time_out"}, int'(time_out0), t);
    chk({tag, " d1.count"},    int'(count1),    c);
    chk({tag, " d1.busy"},     int'(busy1),     b);
    chk({tag, " d1.lfsr_en"},  int'(lfsr_en1),  l);
    chk({tag, " d1.time_out"}, int'(time_out1), t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held 3 cycles, with trigger asserted to confirm reset wins
    rst = 1'b1; en = 1'b1; trigger = 1'b1; rnd_in = 7'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_both($sformatf("rst%0d", i), 0, 0, 0, 0);
    end
    rst = 1'b0; trigger = 1'b0;
    step();
    chk_both("post_rst", 0, 0, 0, 0);

    // N=5, en high: busy k+1..k+5, time_out at k+6
    rnd_in = 7'd5; trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_both($sformatf("n5_c%0d", i), 5 - i, 1, (i == 0) ? 1 : 0, 0);
      step();
    end
    chk_both("n5_done", 0, 0, 0, 1);
    step();
    chk_both("n5_idle", 0, 0, 0, 0);

    // N=3, en alternating; load edge has en=1 which must be ignored
    rnd_in = 7'd3; trigger = 1'b1; en = 1'b1;
    step();
    trigger = 1'b0;
    chk_both("tog_load", 3, 1, 1, 0);
    for (int j = 0; j < 6; j++) begin
      en = (j % 2 == 1);
      step();
      if (j < 5) chk_both($sformatf("tog_c%0d", j), 3 - (j + 1) / 2, 1, 0, 0);
      else       chk_both("tog_done", 0, 0, 0, 1);
    end
    en = 1'b1;
    step();
    chk_both("tog_idle", 0, 0, 0, 0);

    // rnd_in=0 loads 1; time_out two edges after trigger
    rnd_in = 7'd0; trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk_both("zero_load", 1, 1, 1, 0);
    step();
    chk_both("zero_done", 0, 0, 0, 1);
    step();
    chk_both("zero_idle", 0, 0, 0, 0);

    // trigger at count=2: ignored by d0, reloads d1
    rnd_in = 7'd5; trigger = 1'b1;
    step();
    trigger = 1'b0;
    step(); step(); step();
    chk_both("rt_pre", 2, 1, 0, 0);
    rnd_in = 7'd4; trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("rt d0.count",   int'(count0),   1);
    chk("rt d0.lfsr_en", int'(lfsr_en0), 0);
    chk("rt d1.count",   int'(count1),   4);
    chk("rt d1.lfsr_en", int'(lfsr_en1), 1);
    chk("rt d1.busy",    int'(busy1),    1);
    step();
    chk("rt1 d0.time_out", int'(time_out0), 1);
    chk("rt1 d1.count",    int'(count1),    3);
    chk("rt1 d1.time_out", int'(time_out1), 0);
    step();
    chk("rt2 d0.time_out", int'(time_out0), 0);
    chk("rt2 d1.count",    int'(count1),    2);
    step();
    chk("rt3 d1.count",    int'(count1),    1);
    step();
    chk("rt4 d1.time_out", int'(time_out1), 1);
    chk("rt4 d1.busy",     int'(busy1),     0);
    step();
    chk_both("rt_idle", 0, 0, 0, 0);

    // reset mid-COUNT at count=3 aborts without time_out
    rnd_in = 7'd5; trigger = 1'b1;
    step();
    trigger = 1'b0;
    step(); step();
    chk_both("ab_pre", 3, 1, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_both("ab_rst", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_both($sformatf("ab_quiet%0d", i), 0, 0, 0, 0);
    end

    // trigger held high, N=2: d0 fires every 4 cycles; d1 keeps reloading
    rnd_in = 7'd2; trigger = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("hold%0d d0.time_out", c), int'(time_out0), (c % 4 == 3) ? 1 : 0);
      chk($sformatf("hold%0d d0.lfsr_en", c),  int'(lfsr_en0),  (c % 4 == 1) ? 1 : 0);
    end
    chk("hold d1.count",    int'(count1),    2);
    chk("hold d1.time_out", int'(time_out1), 0);
    trigger = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
